i2c_slave_regfile: RTL and testbench
====================================

I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h10, meaning 7-bit I2C address matched (bus byte 8'h20 = write, 8'h21 = read).
REQ-002 Parameter DEPTH, default 8, meaning number of 8-bit registers; power of two, 2..256.
REQ-003 Parameter WR_NACK_LIMIT, default 0, meaning number of data bytes ACKed per write transfer before NACK; 0 means unlimited.
REQ-004 i2c_core_clk_i  input  1  block clock; at least 8x SCL frequency.
REQ-005 preset_ni  input  1  reset, asynchronous, active-low.
REQ-006 scl_i  input  1  bus SCL, asynchronous.
REQ-007 sda_i  input  1  bus SDA, asynchronous.
REQ-008 sda_oe_o  output  1  1 = pull SDA low; 0 = release.
REQ-009 host_addr_i  input  clog2(DEPTH)  local peek index.
REQ-010 host_data_o  output  8  reg[host_addr_i], combinational.
REQ-011 busy_o  output  1  high from address match to STOP.
REQ-012 start_o / stop_o  output  1 each  single-cycle pulse on detected START/STOP.

Function
REQ-013 scl_i and sda_i each pass through a 2-flop synchroniser plus one history flop; all detection uses the synchronised values.
REQ-014 START: sda falls while scl high; STOP: sda rises while scl high; both are detected in any state.
REQ-015 Bits are sampled on a synchronised scl rising edge; sda_oe_o changes only on a synchronised scl falling edge.
REQ-016 States: IDLE, ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, RX_MACK, WAIT_STOP.
REQ-017 START in any state -> ADDR, bit counter cleared; repeated START is legal.
REQ-018 STOP in any state -> IDLE, sda_oe_o = 0 within 1 cycle; busy_o deasserts.
REQ-019 ADDR: 8 bits MSB first; match with R/W=0 -> ACK_ADDR -> RX_PTR; match with R/W=1 -> ACK_ADDR -> TX_DATA; mismatch -> WAIT_STOP, no ACK driven.
REQ-020 ACK phases: sda_oe_o = 1 from the scl fall after bit 8 to the next scl fall.
REQ-021 RX_PTR: received byte modulo DEPTH loads pointer; always ACKed.
REQ-022 RX_DATA: byte written into reg[ptr] at the 8th scl rise; ptr increments, wrapping DEPTH-1 -> 0.
REQ-023 With WR_NACK_LIMIT = N > 0: bytes 1..N are ACKed and written; byte N+1 is not written, is NACKed, and the FSM moves to WAIT_STOP.
REQ-024 TX_DATA: drives reg[ptr] MSB first (sda_oe_o = ~bit); after 8 bits releases SDA -> RX_MACK; ptr increments with wrap.
REQ-025 RX_MACK: master ACK (sda 0) -> TX_DATA with next byte; master NACK -> WAIT_STOP.
REQ-026 Pointer persists across transfers until reset or the next RX_PTR.
REQ-027 START and STOP detected in the same cycle is impossible by construction; when a START or STOP coincides with the 8th-bit sample, START/STOP takes priority and the byte is discarded.

Reset
REQ-028 preset_ni low: state IDLE, all registers and pointer 0, synchroniser flops 1, sda_oe_o 0, busy_o 0, start_o 0, stop_o 0.
REQ-029 Reset asserted mid-transfer releases SDA immediately (asynchronously).

Structure
REQ-030 Shared package i2c_pkg holds the state enumeration, ACK/NACK bit constants and R/W bit position.
REQ-031 One sub-module, i2c_bus_sync, holds the synchronisers and START/STOP/edge detection.
REQ-032 Target size is 150-300 lines of RTL.

Verification
REQ-033 Write 8'h20, 8'h03, 8'hA5, 8'h5A -> all four ACKed; reg[3] = A5, reg[4] = 5A.
REQ-034 Write 8'h20, 8'h07, 8'h11, 8'h22 (DEPTH = 8) -> reg[7] = 11, reg[0] = 22 (wrap).
REQ-035 Write 8'h20, 8'h03, then repeated START, 8'h21, read 2 bytes with ACK then NACK -> SDA shows A5 then 5A; STOP -> busy_o 0.
REQ-036 Address byte 8'h40 -> no ACK; sda_oe_o stays 0 through the following 8 bytes until STOP.
REQ-037 WR_NACK_LIMIT = 2, write 8'h20, 8'h00, 3 data bytes -> third byte NACKed; reg[2] unchanged.
REQ-038 preset_ni pulsed low during the 4th bit of a TX byte -> sda_oe_o 0 at once; reg[*] = 0; the next START is handled normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register file: FSM states and bus bit constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_RX_PTR,
    ST_ACK_PTR,
    ST_RX_DATA,
    ST_ACK_DATA,
    ST_TX_DATA,
    ST_RX_MACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic ACK_BIT  = 1'b0;
  localparam logic NACK_BIT = 1'b1;
  localparam int   RW_BIT   = 0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the core clock and derives SCL edges plus START/STOP events.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);

  // [1:0] form the synchroniser, [2] is the history flop used for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign sda_s    = sda_q[1];
  // SCL must be high in both cycles so a bus event never coincides with an SCL edge
  assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave exposing DEPTH 8-bit registers behind a byte pointer, with local peek port.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR    = 7'h10,
  parameter int         DEPTH         = 8,
  parameter int         WR_NACK_LIMIT = 0,
  localparam int        PW            = $clog2(DEPTH)
) (
  input  logic          i2c_core_clk_i,
  input  logic          preset_ni,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe_o,
  input  logic [PW-1:0] host_addr_i,
  output logic [7:0]    host_data_o,
  output logic          busy_o,
  output logic          start_o,
  output logic          stop_o,
  output i2c_state_e    dbg_state
);

  localparam logic [15:0] LIMIT = 16'(WR_NACK_LIMIT);

  logic scl_rise, scl_fall, sda, start, stop;

  i2c_bus_sync u_sync (
    .clk      (i2c_core_clk_i),
    .rst_n    (preset_ni),
    .scl      (scl_i),
    .sda      (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e    state, state_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shift, shift_next;
  logic [PW-1:0] ptr, ptr_next;
  logic          sda_oe, sda_oe_next;
  logic          ack_on, ack_on_next;
  logic          busy, busy_next;
  logic          read_xfer, read_xfer_next;
  logic [15:0]   wr_cnt, wr_cnt_next;
  logic          wr_en;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_byte;
  logic          byte_done;
  logic [7:0]    regs [DEPTH];

  assign rx_byte   = {shift[6:0], sda};
  assign tx_byte   = regs[ptr];
  assign byte_done = scl_rise && (bit_cnt == 4'd7);

  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      ack_on    <= 1'b0;
      busy      <= 1'b0;
      read_xfer <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      ptr       <= ptr_next;
      sda_oe    <= sda_oe_next;
      ack_on    <= ack_on_next;
      busy      <= busy_next;
      read_xfer <= read_xfer_next;
      wr_cnt    <= wr_cnt_next;
    end
  end

  always_ff @(posedge i2c_core_clk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[ptr] <= rx_byte;
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    ptr_next       = ptr;
    sda_oe_next    = sda_oe;
    ack_on_next    = ack_on;
    busy_next      = busy;
    read_xfer_next = read_xfer;
    wr_cnt_next    = wr_cnt;
    wr_en          = 1'b0;

    // Bus events win over everything, including a coincident 8th-bit sample
    if (stop) begin
      state_next   = ST_IDLE;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      ack_on_next  = 1'b0;
      busy_next    = 1'b0;
    end else if (start) begin
      state_next   = ST_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      ack_on_next  = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_RX_PTR, ST_RX_DATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt + 4'd1;
          end
          if (byte_done) begin
            bit_cnt_next = '0;
            if (state == ST_ADDR) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                busy_next      = 1'b1;
                read_xfer_next = rx_byte[RW_BIT];
                wr_cnt_next    = '0;
                state_next     = ST_ACK_ADDR;
              end else begin
                state_next = ST_WAIT_STOP;
              end
            end else if (state == ST_RX_PTR) begin
              ptr_next   = rx_byte[PW-1:0];
              state_next = ST_ACK_PTR;
            end else if (WR_NACK_LIMIT != 0 && wr_cnt == LIMIT) begin
              state_next = ST_WAIT_STOP;
            end else begin
              wr_en      = 1'b1;
              ptr_next   = ptr + 1'b1;
              state_next = ST_ACK_DATA;
              if (WR_NACK_LIMIT != 0) wr_cnt_next = wr_cnt + 16'd1;
            end
          end
        end

        // Two SCL falls: the first pulls SDA low, the second releases it
        ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_DATA: begin
          if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_next = ~ACK_BIT;
              ack_on_next = 1'b1;
            end else begin
              ack_on_next  = 1'b0;
              bit_cnt_next = '0;
              sda_oe_next  = 1'b0;
              if (state == ST_ACK_ADDR && read_xfer) begin
                shift_next  = tx_byte;
                sda_oe_next = ~tx_byte[7];
                state_next  = ST_TX_DATA;
              end else if (state == ST_ACK_ADDR) begin
                state_next = ST_RX_PTR;
              end else begin
                state_next = ST_RX_DATA;
              end
            end
          end
        end

        ST_TX_DATA: begin
          if (scl_rise) bit_cnt_next = bit_cnt + 4'd1;
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_next  = 1'b0;
              ptr_next     = ptr + 1'b1;
              bit_cnt_next = '0;
              state_next   = ST_RX_MACK;
            end else begin
              sda_oe_next = ~shift[6];
              shift_next  = {shift[6:0], 1'b0};
            end
          end
        end

        ST_RX_MACK: begin
          if (scl_rise && sda == NACK_BIT) begin
            state_next = ST_WAIT_STOP;
          end else if (scl_fall) begin
            shift_next   = tx_byte;
            sda_oe_next  = ~tx_byte[7];
            bit_cnt_next = '0;
            state_next   = ST_TX_DATA;
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe_o    = sda_oe;
  assign busy_o      = busy;
  assign start_o     = start;
  assign stop_o      = stop;
  assign host_data_o = regs[host_addr_i];
  assign dbg_state   = state;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: an I2C master drives two slave instances (unlimited and 2-byte write limit).
module tb_i2c_slave_regfile;

  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sel = 1'b0;
  logic       sda0, sda1, sda_bus;
  logic       oe0, oe1;
  logic [2:0] host_addr0 = '0;
  logic [2:0] host_addr1 = '0;
  logic [7:0] data0, data1;
  logic       busy0, busy1, start0, start1, stop0, stop1;
  i2c_pkg::i2c_state_e dbg0, dbg1;

  int errors = 0;
  int checks = 0;
  int start_cnt0 = 0;
  int stop_cnt0 = 0;
  logic watch_oe = 1'b0;
  logic oe_seen = 1'b0;

  assign sda0    = (sel ? 1'b1 : sda_m) & ~oe0;
  assign sda1    = (sel ? sda_m : 1'b1) & ~oe1;
  assign sda_bus = sel ? sda1 : sda0;

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .i2c_core_clk_i (clk),
    .preset_ni      (rst_n),
    .scl_i          (scl),
    .sda_i          (sda0),
    .sda_oe_o       (oe0),
    .host_addr_i    (host_addr0),
    .host_data_o    (data0),
    .busy_o         (busy0),
    .start_o        (start0),
    .stop_o         (stop0),
    .dbg_state      (dbg0)
  );

  i2c_slave_regfile #(.WR_NACK_LIMIT(2)) dut_lim (
    .i2c_core_clk_i (clk),
    .preset_ni      (rst_n),
    .scl_i          (scl),
    .sda_i          (sda1),
    .sda_oe_o       (oe1),
    .host_addr_i    (host_addr1),
    .host_data_o    (data1),
    .busy_o         (busy1),
    .start_o        (start1),
    .stop_o         (stop1),
    .dbg_state      (dbg1)
  );

  always @(negedge clk) begin
    if (start0) start_cnt0++;
    if (stop0) stop_cnt0++;
    if (watch_oe && oe0) oe_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic peek0(input logic [2:0] idx, input logic [7:0] exp, input string tag);
    host_addr0 = idx;
    #1;
    check(tag, data0, exp);
  endtask

  task automatic peek1(input logic [2:0] idx, input logic [7:0] exp, input string tag);
    host_addr1 = idx;
    #1;
    check(tag, data1, exp);
  endtask

  task automatic send_bit(input logic b, output logic rd);
    #Q; sda_m = b;
    #Q; scl = 1'b1;
    #Q; rd = sda_bus;
    #Q; scl = 1'b0;
  endtask

  task automatic i2c_start();
    #Q; sda_m = 1'b1;
    #Q; scl = 1'b1;
    #Q; sda_m = 1'b0;
    #Q; scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q; sda_m = 1'b0;
    #Q; scl = 1'b1;
    #Q; sda_m = 1'b1;
    #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic r;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, r);
      b = {b[6:0], r};
    end
    send_bit(mack, r);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] rd;
    logic [7:0] junk [8];

    junk[0] = 8'h20; junk[1] = 8'hFF; junk[2] = 8'h00; junk[3] = 8'h55;
    junk[4] = 8'hAA; junk[5] = 8'h21; junk[6] = 8'h3C; junk[7] = 8'hC3;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_oe", oe0, 1'b0);
    check("reset_busy", busy0, 1'b0);
    check("reset_start", start0, 1'b0);
    check("reset_stop", stop0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) peek0(3'(i), 8'h00, "reset_reg");

    // Plain write: 20 03 A5 5A
    i2c_start();
    write_byte(8'h20, ack); check("w1_addr_ack", ack, 1'b1);
    check("w1_busy", busy0, 1'b1);
    write_byte(8'h03, ack); check("w1_ptr_ack", ack, 1'b1);
    write_byte(8'hA5, ack); check("w1_d0_ack", ack, 1'b1);
    write_byte(8'h5A, ack); check("w1_d1_ack", ack, 1'b1);
    i2c_stop();
    check("w1_busy_after_stop", busy0, 1'b0);
    check("w1_oe_after_stop", oe0, 1'b0);
    check("w1_start_pulses", start_cnt0, 1);
    check("w1_stop_pulses", stop_cnt0, 1);
    peek0(3'd3, 8'hA5, "w1_reg3");
    peek0(3'd4, 8'h5A, "w1_reg4");

    // Pointer wrap: 20 07 11 22
    i2c_start();
    write_byte(8'h20, ack); check("w2_addr_ack", ack, 1'b1);
    write_byte(8'h07, ack); check("w2_ptr_ack", ack, 1'b1);
    write_byte(8'h11, ack); check("w2_d0_ack", ack, 1'b1);
    write_byte(8'h22, ack); check("w2_d1_ack", ack, 1'b1);
    i2c_stop();
    peek0(3'd7, 8'h11, "w2_reg7");
    peek0(3'd0, 8'h22, "w2_reg0_wrap");

    // Repeated START into a read of two bytes
    i2c_start();
    write_byte(8'h20, ack); check("r1_waddr_ack", ack, 1'b1);
    write_byte(8'h03, ack); check("r1_ptr_ack", ack, 1'b1);
    i2c_start();
    write_byte(8'h21, ack); check("r1_raddr_ack", ack, 1'b1);
    read_byte(1'b0, rd); check("r1_byte0", rd, 8'hA5);
    read_byte(1'b1, rd); check("r1_byte1", rd, 8'h5A);
    check("r1_busy_before_stop", busy0, 1'b1);
    i2c_stop();
    check("r1_busy_after_stop", busy0, 1'b0);
    check("r1_stop_pulses", stop_cnt0, 3);

    // Pointer persists between a pointer-only write and a later read
    i2c_start();
    write_byte(8'h20, ack);
    write_byte(8'h05, ack);
    write_byte(8'hC3, ack); check("p_d_ack", ack, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte(8'h20, ack);
    write_byte(8'h05, ack); check("p_ptr_ack", ack, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte(8'h21, ack); check("p_raddr_ack", ack, 1'b1);
    read_byte(1'b1, rd); check("p_read", rd, 8'hC3);
    i2c_stop();

    // Foreign address: never drives SDA until STOP
    oe_seen = 1'b0;
    watch_oe = 1'b1;
    i2c_start();
    write_byte(8'h40, ack); check("m_addr_nack", ack, 1'b0);
    check("m_busy", busy0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      write_byte(junk[i], ack);
      check("m_data_nack", ack, 1'b0);
    end
    i2c_stop();
    watch_oe = 1'b0;
    check("m_oe_never", oe_seen, 1'b0);
    peek0(3'd3, 8'hA5, "m_reg3_kept");

    // Write limit of two bytes on the second instance
    sel = 1'b1;
    i2c_start();
    write_byte(8'h20, ack); check("l_addr_ack", ack, 1'b1);
    write_byte(8'h00, ack); check("l_ptr_ack", ack, 1'b1);
    write_byte(8'h11, ack); check("l_d0_ack", ack, 1'b1);
    write_byte(8'h22, ack); check("l_d1_ack", ack, 1'b1);
    write_byte(8'h33, ack); check("l_d2_nack", ack, 1'b0);
    i2c_stop();
    check("l_busy_after_stop", busy1, 1'b0);
    peek1(3'd0, 8'h11, "l_reg0");
    peek1(3'd1, 8'h22, "l_reg1");
    peek1(3'd2, 8'h00, "l_reg2_unwritten");
    sel = 1'b0;

    // Reset during the 4th bit of a read byte (A5: 4th bit is 0, SDA held low)
    i2c_start();
    write_byte(8'h20, ack);
    write_byte(8'h03, ack);
    i2c_start();
    write_byte(8'h21, ack); check("x_raddr_ack", ack, 1'b1);
    send_bit(1'b1, r); check("x_bit7", r, 1'b1);
    send_bit(1'b1, r); check("x_bit6", r, 1'b0);
    send_bit(1'b1, r); check("x_bit5", r, 1'b1);
    #Q; sda_m = 1'b1;
    #Q; scl = 1'b1;
    #Q; check("x_bit4_driven", oe0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("x_oe_async", oe0, 1'b0);
    check("x_busy_async", busy0, 1'b0);
    #Q; scl = 1'b0;
    #Q; rst_n = 1'b1;
    peek0(3'd3, 8'h00, "x_reg3_cleared");
    peek0(3'd4, 8'h00, "x_reg4_cleared");
    peek0(3'd7, 8'h00, "x_reg7_cleared");
    i2c_start();
    write_byte(8'h20, ack); check("x2_addr_ack", ack, 1'b1);
    write_byte(8'h01, ack); check("x2_ptr_ack", ack, 1'b1);
    write_byte(8'h77, ack); check("x2_d_ack", ack, 1'b1);
    i2c_stop();
    peek0(3'd1, 8'h77, "x2_reg1");
    peek0(3'd2, 8'h00, "x2_reg2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
